mem_copy_engine: RTL and testbench



---
 rtl/mem_copy_engine.sv | 187 ++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator for the single-port data memory. A one-cycle start in IDLE
//   launches either a block copy (src -> dst) or a constant fill of dst.
//   The request is range-checked first; rejected requests finish at once
//   with err set. The memory reads combinationally and writes on posedge
//   clk when mem_we=1.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle request, only honoured in IDLE
//   mode          0 = copy, 1 = fill
//   src_addr      copy source word address (ignored in fill mode)
//   dst_addr      destination word address
//   length        number of words to transfer
//   fill_value    constant written in fill mode
//   mem_rdata     read data returned by the memory
//   mem_address   word address to the memory
//   mem_wdata     write data to the memory
//   mem_we        write enable to the memory
//   busy          high in READ, WRITE and FILL
//   done          one-cycle completion pulse
//   err           set with done on a rejected request, held until next start
module mem_copy_engine #(
  parameter int DEPTH = 128,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      fill_value,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FILL,
    S_FINISH
  } state_t;

  localparam logic [32:0]      DEPTH_X = 33'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  state_t             state_q, state_d;
  logic [31:0]        src_ptr_q, src_ptr_d;
  logic [31:0]        dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        fill_q, fill_d;
  logic               desc_q, desc_d;
  logic               err_q, err_d;

  // Range sums are 33 bits wide so an address near 2^32 cannot wrap into
  // an apparently legal range.
  logic [32:0] len_x;
  logic [32:0] src_end;
  logic [32:0] dst_end;
  logic [31:0] len32;
  logic        range_bad;
  logic        overlap;

  assign len_x     = 33'(length);
  assign len32     = 32'(length);
  assign src_end   = {1'b0, src_addr} + len_x;
  assign dst_end   = {1'b0, dst_addr} + len_x;
  assign range_bad = (dst_end > DEPTH_X) || (!mode && (src_end > DEPTH_X));
  // A destination starting inside the source block would overwrite source
  // words before they are read; copying from the top end down avoids that.
  assign overlap   = (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end);

  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      fill_q    <= '0;
      desc_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      desc_q    <= desc_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    fill_d      = fill_q;
    desc_d      = desc_q;
    err_d       = err_q;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;
    mem_we      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fill_d = fill_value;
          cnt_d  = length;
          err_d  = 1'b0;
          desc_d = 1'b0;
          if (range_bad) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else if (length == '0) begin
            state_d = S_FINISH;
          end else if (mode) begin
            dst_ptr_d = dst_addr;
            state_d   = S_FILL;
          end else begin
            desc_d = overlap;
            if (overlap) begin
              src_ptr_d = src_addr + len32 - 32'd1;
              dst_ptr_d = dst_addr + len32 - 32'd1;
            end else begin
              src_ptr_d = src_addr;
              dst_ptr_d = dst_addr;
            end
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        busy        = 1'b1;
        mem_address = src_ptr_q;
        data_d      = mem_rdata;
        state_d     = S_WRITE;
      end

      S_WRITE: begin
        busy        = 1'b1;
        mem_address = dst_ptr_q;
        mem_wdata   = data_q;
        mem_we      = 1'b1;
        src_ptr_d   = desc_q ? src_ptr_q - 32'd1 : src_ptr_q + 32'd1;
        dst_ptr_d   = desc_q ? dst_ptr_q - 32'd1 : dst_ptr_q + 32'd1;
        cnt_d       = cnt_q - ONE_LEN;
        state_d     = (cnt_q > ONE_LEN) ? S_READ : S_FINISH;
      end

      S_FILL: begin
        busy        = 1'b1;
        mem_address = dst_ptr_q;
        mem_wdata   = fill_q;
        mem_we      = 1'b1;
        dst_ptr_d   = dst_ptr_q + 32'd1;
        cnt_d       = cnt_q - ONE_LEN;
        state_d     = (cnt_q > ONE_LEN) ? S_FILL : S_FINISH;
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: a behavioural memory, a memmove-style
// reference model feeding an expected-event queue, and a negedge monitor
// that pops and compares every active bus cycle and done pulse.
module tb_mem_copy_engine;

  localparam int DEPTH = 128;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic [31:0]      fill_value = '0;
  logic [31:0]      mem_rdata;
  logic [31:0]      mem_address;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic             busy;
  logic             done;
  logic             err;

  mem_copy_engine #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .mem_rdata(mem_rdata),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory under the engine: combinational read, posedge write.
  logic [31:0] mem [DEPTH];
  logic        preset = 1'b1;
  assign mem_rdata = (mem_address < 32'(DEPTH)) ? mem[mem_address[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(4 * (i + 1));
    end else if (mem_we && (mem_address < 32'(DEPTH))) begin
      mem[mem_address[6:0]] <= mem_wdata;
    end
  end

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    bit          err;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_bus(logic [31:0] a, bit we, logic [31:0] wd);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.we = we; e.wdata = wd; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(bit er);
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.err = er;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with busy, done or mem_we must match the next
  // expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en && (busy || done || mem_we)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_activity", {29'b0, busy, done, mem_we}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("done_vs_busy", {31'b0, done}, {31'b0, e.is_done});
        check("busy", {31'b0, busy}, {31'b0, !e.is_done});
        if (e.is_done) begin
          check("done_err", {31'b0, err}, {31'b0, e.err});
          check("done_we", {31'b0, mem_we}, 32'h0);
          check("done_addr", mem_address, 32'h0);
          check("done_wdata", mem_wdata, 32'h0);
        end else begin
          check("bus_addr", mem_address, e.addr);
          check("bus_we", {31'b0, mem_we}, {31'b0, e.we});
          if (e.we) check("bus_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // Reference model: memmove semantics on ref_mem, plus the bus trace the
  // engine should produce. Returns the expected cycle of the done pulse.
  task automatic model(bit md, logic [31:0] s, logic [31:0] d,
                       logic [LEN_W-1:0] n, logic [31:0] fv, output int lat);
    longint      ls, ld, ln;
    bit          bad, desc;
    int          i;
    logic [31:0] orig [DEPTH];
    ls = longint'(s); ld = longint'(d); ln = longint'(n);
    bad = (ld + ln > DEPTH) || (!md && (ls + ln > DEPTH));
    if (bad || n == 0) begin
      push_done(bad);
      lat = 1;
      return;
    end
    orig = ref_mem;
    if (md) begin
      for (int k = 0; k < int'(n); k++) begin
        push_bus(d + 32'(k), 1'b1, fv);
        ref_mem[int'(ld) + k] = fv;
      end
      lat = int'(n) + 1;
    end else begin
      desc = (ld > ls) && (ld < ls + ln);
      for (int k = 0; k < int'(n); k++) begin
        i = desc ? int'(n) - 1 - k : k;
        push_bus(s + 32'(i), 1'b0, 32'h0);
        push_bus(d + 32'(i), 1'b1, orig[int'(ls) + i]);
        ref_mem[int'(ld) + i] = orig[int'(ls) + i];
      end
      lat = 2 * int'(n) + 1;
    end
    push_done(1'b0);
  endtask

  task automatic scramble_inputs();
    mode       = 1'($urandom);
    src_addr   = $urandom_range(0, 127);
    dst_addr   = $urandom_range(0, 127);
    length     = LEN_W'($urandom_range(1, 8));
    fill_value = $urandom;
  endtask

  task automatic check_mem(string name);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(name, 32'(bad), 32'h0);
  endtask

  task automatic do_xfer(bit md, logic [31:0] s, logic [31:0] d,
                         logic [LEN_W-1:0] n, logic [31:0] fv, bit poke);
    int lat, cyc;
    model(md, s, d, n, fv, lat);
    @(posedge clk); #1;
    mode = md; src_addr = s; dst_addr = d; length = n; fill_value = fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    cyc = 1;
    while (!done && cyc < 600) begin
      start = poke && (cyc == 2 || cyc == 3);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    if (poke) begin
      // Request arriving during the FINISH cycle must also be dropped.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    check_mem("mem_image");
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(4 * (i + 1));
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    preset = 1'b0;
    mon_en = 1'b1;

    do_xfer(1'b0, 32'd0, 32'd20, 8'd4, 32'h0, 1'b0);
    do_xfer(1'b0, 32'd0, 32'd1, 8'd3, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h0, 32'd30, 8'd5, 32'hDEADBEEF, 1'b0);
    do_xfer(1'b0, 32'd5, 32'd9, 8'd0, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h0, 32'd126, 8'd4, 32'h12345678, 1'b0);
    do_xfer(1'b0, 32'd0, 32'd126, 8'd4, 32'h0, 1'b0);
    do_xfer(1'b1, 32'h0, 32'd124, 8'd4, 32'hA5A5A5A5, 1'b0);
    do_xfer(1'b0, 32'd2, 32'hFFFFFFFF, 8'd2, 32'h0, 1'b0);
    do_xfer(1'b0, 32'hFFFFFFFE, 32'd2, 8'd4, 32'h0, 1'b0);
    do_xfer(1'b0, 32'd10, 32'd10, 8'd3, 32'h0, 1'b0);
    do_xfer(1'b0, 32'd8, 32'd6, 8'd5, 32'h0, 1'b0);
    do_xfer(1'b0, 32'd40, 32'd50, 8'd4, 32'h0, 1'b1);

    // Reset in the third cycle of a 4-word copy: only the first word lands.
    begin : mid_reset
      int cyc;
      push_bus(32'd40, 1'b0, 32'h0);
      push_bus(32'd60, 1'b1, ref_mem[40]);
      push_bus(32'd41, 1'b0, 32'h0);
      ref_mem[60] = ref_mem[40];
      @(posedge clk); #1;
      mode = 1'b0; src_addr = 32'd40; dst_addr = 32'd60; length = 8'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (cyc < 3) begin
        @(posedge clk); #1;
        cyc++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_we", {31'b0, mem_we}, 32'h0);
      check("midrst_busy", {31'b0, busy}, 32'h0);
      check("midrst_done", {31'b0, done}, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_queue", 32'(exp_q.size()), 32'h0);
      check_mem("midrst_mem");
      exp_q.delete();
    end
    do_xfer(1'b0, 32'd40, 32'd60, 8'd4, 32'h0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [LEN_W-1:0] n;
      n = LEN_W'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) n = LEN_W'($urandom_range(0, 255));
      do_xfer(1'($urandom), 32'($urandom_range(0, 130)), 32'($urandom_range(0, 130)),
              n, $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
